// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage: FSM states,
// reserved opcodes and the opcode field width.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2,
    HAVE  = 2'd3
  } fetch_state_e;

  // Opcode occupies the top OPCODE_WIDTH bits of a word; operand is the rest.
  localparam int unsigned OPCODE_WIDTH = 32'd4;
  localparam int unsigned OPERAND_LSB  = 32'd0;

  localparam logic [OPCODE_WIDTH-1:0] NOP  = 4'b0000;
  localparam logic [OPCODE_WIDTH-1:0] HALT = 4'b1111;

  function automatic logic is_halt(input logic [OPCODE_WIDTH-1:0] op);
    return (op == HALT);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory request/acknowledge bus between the fetch stage
// (master) and instruction memory (slave).
interface instr_fetch_unit_if #(
  parameter int PC_WIDTH    = 32'd8,
  parameter int INSTR_WIDTH = 32'd8
);
  logic                   MemReq;
  logic [PC_WIDTH-1:0]    MemAddr;
  logic                   MemAck;
  logic [INSTR_WIDTH-1:0] MemData;

  modport master (output MemReq, output MemAddr, input MemAck, input MemData);
  modport slave  (input MemReq, input MemAddr, output MemAck, output MemData);
endinterface

// File: rtl/pc_reg.sv
// Program counter register: jump-over-increment priority, immediate zero-extension
// and the optional non-wrapping overflow guard enabled by FETCH_PC_OVF_EN.
module pc_reg
  import fetch_pkg::*;
#(
  parameter int                  PC_WIDTH      = 32'd8,
  parameter int                  OPERAND_WIDTH = 32'd4,
  parameter logic [PC_WIDTH-1:0] RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     inc_pc,
  input  logic                     load_pc,
  input  logic                     sel_pc,
  input  logic [PC_WIDTH-1:0]      reg_data,
  input  logic [OPERAND_WIDTH-1:0] operand,
  output logic [PC_WIDTH-1:0]      pc,
  output logic [PC_WIDTH-1:0]      pc_next,
  output logic                     pc_change,
  output logic                     ovf_hit,
  output logic                     pc_overflow
);

  logic [PC_WIDTH-1:0] pc_r;
  logic [PC_WIDTH-1:0] pc_next_s;
  logic [PC_WIDTH-1:0] target_s;
  logic                ovf_hit_s;
  logic                ovf_r;

  // Jump target source select; the immediate is zero-extended.
  always_comb begin
    target_s = reg_data;
    if (sel_pc) begin
      target_s = PC_WIDTH'(operand);
    end else begin
      target_s = reg_data;
    end
  end

  // Next PC: a jump beats an increment; an increment at all-ones may be refused.
  always_comb begin
    pc_next_s = pc_r;
    ovf_hit_s = 1'b0;
    if (load_pc) begin
      pc_next_s = target_s;
    end else if (inc_pc) begin
`ifdef FETCH_PC_OVF_EN
      if (&pc_r) begin
        pc_next_s = pc_r;
        ovf_hit_s = 1'b1;
      end else begin
        pc_next_s = pc_r + PC_WIDTH'(1'b1);
      end
`else
      pc_next_s = pc_r + PC_WIDTH'(1'b1);
`endif
    end else begin
      pc_next_s = pc_r;
    end
  end

  // PC register and sticky overflow flag (only reset clears it).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_r  <= RESET_PC;
      ovf_r <= 1'b0;
    end else begin
      pc_r  <= pc_next_s;
      ovf_r <= ovf_r | ovf_hit_s;
    end
  end

  assign pc          = pc_r;
  assign pc_next     = pc_next_s;
  assign pc_change   = load_pc | inc_pc;
  assign ovf_hit     = ovf_hit_s;
  assign pc_overflow = ovf_r;

endmodule

// File: rtl/instr_fetch_unit.sv
// PC/IR fetch stage: fetch FSM, fetch buffer and instruction register feeding the
// controller. Optional non-wrapping PC overflow guard is enabled by FETCH_PC_OVF_EN.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                  PC_WIDTH    = 32'd8,
  parameter int                  INSTR_WIDTH = 32'd8,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                      Clk,
  input  logic                      reset,
  input  logic                      LoadIR,
  input  logic                      IncPC,
  input  logic                      LoadPC,
  input  logic                      SelPC,
  input  logic [PC_WIDTH-1:0]       RegData,
  instr_fetch_unit_if.master        mem,
  output logic [OPCODE_WIDTH-1:0]   Opcode,
  output logic [INSTR_WIDTH-5:0]    Operand,
  output logic [PC_WIDTH-1:0]       PC,
  output logic                      Ready,
  output logic                      PcOverflow
);

  localparam int OPERAND_WIDTH = INSTR_WIDTH - OPCODE_WIDTH;

  fetch_state_e           state_r, next_state_s;
  logic [INSTR_WIDTH-1:0] ir_r, buf_r;
  logic [PC_WIDTH-1:0]    addr_r, addr_s, pc_s, pc_next_s;
  logic                   mem_req_r, mem_req_s, ready_r, ready_s, stop_r;
  logic                   pc_change_s, ovf_hit_s, ir_load_s, halt_load_s, buf_load_s;

  pc_reg #(
    .PC_WIDTH      (PC_WIDTH),
    .OPERAND_WIDTH (OPERAND_WIDTH),
    .RESET_PC      (RESET_PC)
  ) u_pc_reg (
    .clk         (Clk),
    .reset       (reset),
    .inc_pc      (IncPC),
    .load_pc     (LoadPC),
    .sel_pc      (SelPC),
    .reg_data    (RegData),
    .operand     (ir_r[OPERAND_WIDTH-1:OPERAND_LSB]),
    .pc          (pc_s),
    .pc_next     (pc_next_s),
    .pc_change   (pc_change_s),
    .ovf_hit     (ovf_hit_s),
    .pc_overflow (PcOverflow)
  );

  assign ir_load_s   = LoadIR && (state_r == HAVE);
  assign halt_load_s = ir_load_s && is_halt(buf_r[INSTR_WIDTH-1 -: OPCODE_WIDTH]);

  // Next-state: overflow parks the stage; a PC change mid-request drains the stale word.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (ovf_hit_s)                                                   next_state_s = IDLE;
        else if (LoadPC)                                                 next_state_s = REQ;
        else if (is_halt(ir_r[INSTR_WIDTH-1 -: OPCODE_WIDTH]) || stop_r) next_state_s = IDLE;
        else                                                             next_state_s = REQ;
      end
      REQ: begin
        if (ovf_hit_s)        next_state_s = IDLE;
        else if (pc_change_s) next_state_s = mem.MemAck ? REQ : DRAIN;
        else if (mem.MemAck)  next_state_s = HAVE;
        else                  next_state_s = REQ;
      end
      DRAIN: begin
        if (ovf_hit_s)       next_state_s = IDLE;
        else if (mem.MemAck) next_state_s = REQ;
        else                 next_state_s = DRAIN;
      end
      HAVE: begin
        if (ovf_hit_s)                    next_state_s = IDLE;
        else if (halt_load_s && !LoadPC)  next_state_s = IDLE;
        else if (pc_change_s)             next_state_s = REQ;
        else                              next_state_s = HAVE;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Registered-output precompute; DRAIN keeps the issued address on the bus.
  always_comb begin
    mem_req_s  = (next_state_s == REQ) || (next_state_s == DRAIN);
    ready_s    = (next_state_s == HAVE);
    buf_load_s = (state_r == REQ) && (next_state_s == HAVE);
    addr_s     = addr_r;
    if (next_state_s == DRAIN) begin
      addr_s = addr_r;
    end else begin
      addr_s = pc_next_s;
    end
  end

  // State and bus-facing output registers.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      mem_req_r <= 1'b0;
      ready_r   <= 1'b0;
      addr_r    <= RESET_PC;
    end else begin
      state_r   <= next_state_s;
      mem_req_r <= mem_req_s;
      ready_r   <= ready_s;
      addr_r    <= addr_s;
    end
  end

  // Fetch buffer, instruction register and overflow park flag.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      buf_r  <= '0;
      ir_r   <= {NOP, {OPERAND_WIDTH{1'b0}}};
      stop_r <= 1'b0;
    end else begin
      if (buf_load_s) buf_r <= mem.MemData;
      if (ir_load_s)  ir_r  <= buf_r;
      if (ovf_hit_s)   stop_r <= 1'b1;
      else if (LoadPC) stop_r <= 1'b0;
    end
  end

  assign mem.MemReq  = mem_req_r;
  assign mem.MemAddr = addr_r;
  assign Ready       = ready_r;
  assign PC          = pc_s;
  assign Opcode      = ir_r[INSTR_WIDTH-1 -: OPCODE_WIDTH];
  assign Operand     = ir_r[OPERAND_WIDTH-1:OPERAND_LSB];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed plus randomized bench for instr_fetch_unit, checked against a
// transaction-level reference model (request / stale / buffer-valid bookkeeping).
module tb_instr_fetch_unit;

`ifdef FETCH_PC_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       reset, LoadIR, IncPC, LoadPC, SelPC;
  logic [7:0] RegData, PC;
  logic [3:0] Opcode, Operand;
  logic       Ready, PcOverflow;

  instr_fetch_unit_if #(.PC_WIDTH(8), .INSTR_WIDTH(8)) mif();

  instr_fetch_unit #(.PC_WIDTH(8), .INSTR_WIDTH(8), .RESET_PC(8'h00)) dut (
    .Clk(Clk), .reset(reset), .LoadIR(LoadIR), .IncPC(IncPC), .LoadPC(LoadPC),
    .SelPC(SelPC), .RegData(RegData), .mem(mif), .Opcode(Opcode), .Operand(Operand),
    .PC(PC), .Ready(Ready), .PcOverflow(PcOverflow)
  );

  always #5 Clk = ~Clk;

  logic [7:0] mem [256];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: what memory request is outstanding, whether it is stale,
  // and whether a fetched word for the current PC is buffered.
  logic [7:0] m_pc, m_ir, m_buf, m_addr;
  bit m_req, m_stale, m_ready, m_parked, m_ovf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 8'h00; m_ir = 8'h00; m_buf = 8'h00; m_addr = 8'h00;
    m_req = 1'b0; m_stale = 1'b0; m_ready = 1'b0; m_parked = 1'b0; m_ovf = 1'b0;
  endtask

  task automatic model_step(input bit ldir, inc, ldpc, sel, input logic [7:0] rd,
                            input bit ack, input logic [7:0] data);
    logic [7:0] npc;
    bit change, ovf_now, ir_ld, halt_ld;
    change  = ldpc || inc;
    ovf_now = 1'b0;
    if (ldpc)                                     npc = sel ? {4'h0, m_ir[3:0]} : rd;
    else if (inc && OVF_EN && (m_pc == 8'hFF)) begin npc = m_pc; ovf_now = 1'b1; end
    else if (inc)                                 npc = m_pc + 8'd1;
    else                                          npc = m_pc;
    ir_ld   = ldir && m_ready;
    halt_ld = ir_ld && (m_buf[7:4] == 4'hF);
    if (ovf_now) begin
      m_req = 1'b0; m_ready = 1'b0; m_stale = 1'b0; m_parked = 1'b1; m_ovf = 1'b1;
    end else if (m_ready) begin
      if (halt_ld && !ldpc) m_ready = 1'b0;
      else if (change) begin m_ready = 1'b0; m_req = 1'b1; m_addr = npc; end
    end else if (m_req) begin
      if (ack && (m_stale || change)) begin m_stale = 1'b0; m_addr = npc; end
      else if (ack) begin m_req = 1'b0; m_ready = 1'b1; m_buf = data; end
      else if (change) m_stale = 1'b1;
    end else if (ldpc || ((m_ir[7:4] != 4'hF) && !m_parked)) begin
      m_req = 1'b1; m_addr = npc;
    end
    if (ldpc) m_parked = 1'b0;
    if (ir_ld) m_ir = m_buf;
    m_pc = npc;
  endtask

  task automatic compare_all();
    check("pc",      32'(PC),         32'(m_pc));
    check("opcode",  32'(Opcode),     32'(m_ir[7:4]));
    check("operand", 32'(Operand),    32'(m_ir[3:0]));
    check("ready",   32'(Ready),      32'(m_ready));
    check("memreq",  32'(mif.MemReq), 32'(m_req));
    check("pcovf",   32'(PcOverflow), 32'(m_ovf));
    if (m_req) check("memaddr", 32'(mif.MemAddr), 32'(m_addr));
  endtask

  // One clock: drive at the falling edge, advance, compare at the next falling edge.
  task automatic step(input bit ldir, inc, ldpc, sel, input logic [7:0] rd, input bit ack);
    logic [7:0] data;
    data = mem[m_addr];
    LoadIR = ldir; IncPC = inc; LoadPC = ldpc; SelPC = sel; RegData = rd;
    mif.MemAck = ack; mif.MemData = data;
    model_step(ldir, inc, ldpc, sel, rd, ack, data);
    @(posedge Clk);
    @(negedge Clk);
    compare_all();
  endtask

  task automatic settle();
    for (int i = 0; i < 8 && !m_ready; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    check("settle_ready", 32'(Ready), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_reset();
    check("rst_memreq", 32'(mif.MemReq), 32'd0);
    check("rst_pc",     32'(PC),         32'd0);
    check("rst_ready",  32'(Ready),      32'd0);
    LoadIR = 1'b0; IncPC = 1'b0; LoadPC = 1'b0; SelPC = 1'b0; RegData = 8'h00;
    mif.MemAck = 1'b1; mif.MemData = 8'h5A;
    @(posedge Clk);
    @(negedge Clk);
    compare_all();
    check("rst_memaddr", 32'(mif.MemAddr), 32'd0);
    reset = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 8'hEF));
    mem[8'h00] = 8'h1A; mem[8'h02] = 8'hF5; mem[8'h03] = 8'h2B; mem[8'h04] = 8'h75;
    mem[8'h10] = 8'h33; mem[8'h20] = 8'hF0; mem[8'hFF] = 8'h11;
    model_reset();
    reset = 1'b0; LoadIR = 1'b0; IncPC = 1'b0; LoadPC = 1'b0; SelPC = 1'b0;
    RegData = 8'h00; mif.MemAck = 1'b0; mif.MemData = 8'h00;
    repeat (2) @(negedge Clk);
    compare_all();
    check("rst_addr", 32'(mif.MemAddr), 32'd0);
    reset = 1'b1;

    // Reset release, zero-latency memory, first IR load.
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    check("t1_req",  32'(mif.MemReq),  32'd1);
    check("t1_addr", 32'(mif.MemAddr), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    check("t1_ready", 32'(Ready), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    check("t1_opcode",  32'(Opcode),  32'd1);
    check("t1_operand", 32'(Operand), 32'hA);

    // Increment from 3 with a three-cycle memory.
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h03, 1'b0);
    settle();
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    check("t2_addr_c1", 32'(mif.MemAddr), 32'd4);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    check("t2_addr_c2", 32'(mif.MemAddr), 32'd4);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    check("t2_addr_c3", 32'(mif.MemAddr), 32'd4);
    check("t2_notready", 32'(Ready), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    check("t2_ready", 32'(Ready), 32'd1);

    // Jumps: immediate, register, and jump-over-increment.
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'hEE, 1'b0);
    check("t3_pc_imm", 32'(PC), 32'h05);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h9C, 1'b0);
    check("t3_pc_reg", 32'(PC), 32'h9C);
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h40, 1'b0);
    check("t3_pc_prio", 32'(PC), 32'h40);
    settle();

    // PC change while a request is pending: drain and discard the stale word.
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h02, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    check("t4_drain_addr", 32'(mif.MemAddr), 32'd2);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    check("t4_drain_hold", 32'(mif.MemAddr), 32'd2);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    check("t4_new_addr", 32'(mif.MemAddr), 32'd3);
    check("t4_no_ready", 32'(Ready), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    check("t4_ir_kept", 32'(Opcode), 32'd7);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    check("t4_ir_new", 32'({Opcode, Operand}), 32'h2B);

    // HALT stops fetching until a jump.
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h20, 1'b0);
    settle();
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'(i % 2));
      check("t5_halted", 32'(mif.MemReq), 32'd0);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h10, 1'b0);
    check("t5_resume_req",  32'(mif.MemReq),  32'd1);
    check("t5_resume_addr", 32'(mif.MemAddr), 32'h10);
    settle();
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    // Increment at all-ones.
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b0);
    settle();
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
`ifdef FETCH_PC_OVF_EN
    check("t6_pc_hold", 32'(PC), 32'hFF);
    check("t6_ovf",     32'(PcOverflow), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      check("t6_parked", 32'(mif.MemReq), 32'd0);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h30, 1'b0);
    check("t6_resume", 32'(mif.MemReq), 32'd1);
    check("t6_sticky", 32'(PcOverflow), 32'd1);
`else
    check("t6_pc_wrap", 32'(PC), 32'h00);
    check("t6_wrap_req", 32'(mif.MemReq), 32'd1);
    check("t6_wrap_addr", 32'(mif.MemAddr), 32'h00);
    check("t6_no_ovf", 32'(PcOverflow), 32'd0);
`endif

    // Randomized traffic, including spurious acks and one mid-run reset.
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] rd;
      if (i == 1500) do_reset();
      rd = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
      step($urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 1) == 1, rd,
           m_req ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
